// File: rtl/instr_fetch_queue.sv
// Instruction fetch unit: walks the PC stream, issues word reads to instruction memory
// and queues returned {pc, instruction} pairs for decode; a taken-branch redirect flushes.
//
// state | meaning
// FETCH | may issue a request at fetch_addr when a queue slot is free
// WAIT  | one request in flight, its response is pushed into the queue
// DROP  | one stale request in flight (redirected), its response is discarded
module instr_fetch_queue #(
   parameter logic [63:0] RESET_PC = 64'd0,
   parameter int          DEPTH    = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        redirect,
   input  logic [63:0] redirect_pc,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [63:0] imem_req_addr,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr_data,
   output logic [63:0] instr_pc
);
   localparam int          PW   = $clog2(DEPTH);
   localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

   typedef enum logic [1:0] {FETCH, WAIT, DROP} state_t;

   state_t          state;
   logic [63:0]     fetch_addr;
   logic [PW:0]     count;
   logic [PW-1:0]   rd_ptr;
   logic [PW-1:0]   wr_ptr;
   logic [63:0]     pc_mem   [DEPTH];
   logic [31:0]     data_mem [DEPTH];

   logic req_fire;
   logic push;
   logic pop;
   logic unused_pc_bits;

   // Alignment bits of the branch target are dropped on purpose.
   assign unused_pc_bits = ^redirect_pc[1:0];

   assign imem_req_valid = (state == FETCH) && (count < FULL) && !redirect;
   assign imem_req_addr  = fetch_addr;
   assign instr_valid    = (count != '0);
   assign instr_data     = data_mem[rd_ptr];
   assign instr_pc       = pc_mem[rd_ptr];

   assign req_fire = imem_req_valid && imem_req_ready;
   assign push     = (state == WAIT) && imem_resp_valid && !redirect;
   assign pop      = instr_valid && instr_ready && !redirect;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= FETCH;
         fetch_addr <= RESET_PC;
         count      <= '0;
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            pc_mem[i]   <= '0;
            data_mem[i] <= '0;
         end
      end else if (redirect) begin
         count      <= '0;
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         fetch_addr <= {redirect_pc[63:2], 2'b00};
         case (state)
            FETCH:   state <= FETCH;
            WAIT:    state <= imem_resp_valid ? FETCH : DROP;
            DROP:    state <= imem_resp_valid ? FETCH : DROP;
            default: state <= FETCH;
         endcase
      end else begin
         case (state)
            FETCH: begin
               if (req_fire) begin
                  fetch_addr <= fetch_addr + 64'd4;
                  state      <= WAIT;
               end
            end
            WAIT:    if (imem_resp_valid) state <= FETCH;
            DROP:    if (imem_resp_valid) state <= FETCH;
            default: state <= FETCH;
         endcase

         // fetch_addr already points past the word being returned.
         if (push) begin
            pc_mem[wr_ptr]   <= fetch_addr - 64'd4;
            data_mem[wr_ptr] <= imem_resp_data;
            wr_ptr           <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;

         if (push && !pop)      count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
      end
   end
endmodule

// File: tb/tb_instr_fetch_queue.sv
// Self-checking bench for instr_fetch_queue: per-cycle vector table for streaming and
// backpressure, plus directed sequences for redirect, wrap and asynchronous reset.
module tb_instr_fetch_queue;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        redirect;
   logic [63:0] redirect_pc;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [63:0] imem_req_addr;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr_data;
   logic [63:0] instr_pc;

   always #5 clk = ~clk;

   instr_fetch_queue #(.RESET_PC(64'h1000), .DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .redirect(redirect), .redirect_pc(redirect_pc),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
      .imem_req_addr(imem_req_addr),
      .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr_data(instr_data), .instr_pc(instr_pc)
   );

   int checks   = 0;
   int failures = 0;

   // memory model state
   bit          pend;
   logic [63:0] pend_addr;
   int          pend_cnt;
   int          lat;
   int          req_count;

   typedef struct {
      bit          rdy;
      bit          redir;
      logic [63:0] rpc;
      bit          e_rv;
      logic [63:0] e_ra;
      bit          e_iv;
      logic [63:0] e_ipc;
   } vec_t;

   vec_t vecs[21];

   function automatic logic [31:0] mem_word(input logic [63:0] a);
      return a[31:0] ^ 32'h5A5A_A5A5;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Call after the negedge of a cycle: logs acceptance, advances to posedge+1, drives response.
   task automatic next_cycle();
      if (imem_req_valid && imem_req_ready) begin
         pend      = 1'b1;
         pend_addr = imem_req_addr;
         pend_cnt  = lat;
         req_count++;
      end
      @(posedge clk);
      #1;
      imem_resp_valid = 1'b0;
      if (pend) begin
         pend_cnt--;
         if (pend_cnt == 0) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_word(pend_addr);
            pend            = 1'b0;
         end
      end
   endtask

   // Drain any in-flight read, then redirect to base with an empty queue.
   task automatic prep(input logic [63:0] base, input int latency);
      imem_req_ready = 1'b0;
      instr_ready    = 1'b1;
      redirect       = 1'b0;
      for (int k = 0; k < 8 && pend; k++) next_cycle();
      chk("drain", {63'd0, pend}, 64'd0);
      next_cycle();
      redirect    = 1'b1;
      redirect_pc = base;
      @(negedge clk);
      next_cycle();
      redirect       = 1'b0;
      lat            = latency;
      imem_req_ready = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vecs[0]  = '{1'b1, 1'b0, 64'h0, 1'b1, 64'h1000, 1'b0, 64'h0};
      vecs[1]  = '{1'b1, 1'b0, 64'h0, 1'b0, 64'h0,    1'b0, 64'h0};
      vecs[2]  = '{1'b1, 1'b0, 64'h0, 1'b1, 64'h1004, 1'b1, 64'h1000};
      vecs[3]  = '{1'b1, 1'b0, 64'h0, 1'b0, 64'h0,    1'b0, 64'h0};
      vecs[4]  = '{1'b1, 1'b0, 64'h0, 1'b1, 64'h1008, 1'b1, 64'h1004};
      vecs[5]  = '{1'b1, 1'b0, 64'h0, 1'b0, 64'h0,    1'b0, 64'h0};
      vecs[6]  = '{1'b1, 1'b0, 64'h0, 1'b1, 64'h100C, 1'b1, 64'h1008};
      vecs[7]  = '{1'b0, 1'b1, 64'h0, 1'b0, 64'h0,    1'b0, 64'h0};
      vecs[8]  = '{1'b0, 1'b0, 64'h0, 1'b1, 64'h0,    1'b0, 64'h0};
      vecs[9]  = '{1'b0, 1'b0, 64'h0, 1'b0, 64'h0,    1'b0, 64'h0};
      vecs[10] = '{1'b0, 1'b0, 64'h0, 1'b1, 64'h4,    1'b1, 64'h0};
      vecs[11] = '{1'b0, 1'b0, 64'h0, 1'b0, 64'h0,    1'b1, 64'h0};
      vecs[12] = '{1'b0, 1'b0, 64'h0, 1'b1, 64'h8,    1'b1, 64'h0};
      vecs[13] = '{1'b0, 1'b0, 64'h0, 1'b0, 64'h0,    1'b1, 64'h0};
      vecs[14] = '{1'b0, 1'b0, 64'h0, 1'b1, 64'hC,    1'b1, 64'h0};
      vecs[15] = '{1'b0, 1'b0, 64'h0, 1'b0, 64'h0,    1'b1, 64'h0};
      vecs[16] = '{1'b0, 1'b0, 64'h0, 1'b0, 64'h0,    1'b1, 64'h0};
      vecs[17] = '{1'b1, 1'b0, 64'h0, 1'b0, 64'h0,    1'b1, 64'h0};
      vecs[18] = '{1'b0, 1'b0, 64'h0, 1'b1, 64'h10,   1'b1, 64'h4};
      vecs[19] = '{1'b0, 1'b0, 64'h0, 1'b0, 64'h0,    1'b1, 64'h4};
      vecs[20] = '{1'b0, 1'b0, 64'h0, 1'b0, 64'h0,    1'b1, 64'h4};

      rst_n = 1'b0; redirect = 1'b0; redirect_pc = '0;
      imem_req_ready = 1'b1; imem_resp_valid = 1'b0; imem_resp_data = '0;
      instr_ready = 1'b1;
      pend = 1'b0; pend_addr = '0; pend_cnt = 0; lat = 1; req_count = 0;

      repeat (3) @(posedge clk);
      #1;
      chk("reset instr_valid", {63'd0, instr_valid}, 64'd0);
      chk("reset instr_data", {32'd0, instr_data}, 64'd0);
      chk("reset instr_pc", instr_pc, 64'd0);
      chk("reset req_addr", imem_req_addr, 64'h1000);
      rst_n = 1'b1;

      // streaming, coincident redirect+response, then backpressure to full
      for (int i = 0; i < 21; i++) begin
         instr_ready = vecs[i].rdy;
         redirect    = vecs[i].redir;
         redirect_pc = vecs[i].rpc;
         @(negedge clk);
         chk($sformatf("v%0d req_valid", i), {63'd0, imem_req_valid}, {63'd0, vecs[i].e_rv});
         if (vecs[i].e_rv)
            chk($sformatf("v%0d req_addr", i), imem_req_addr, vecs[i].e_ra);
         chk($sformatf("v%0d instr_valid", i), {63'd0, instr_valid}, {63'd0, vecs[i].e_iv});
         if (vecs[i].e_iv) begin
            chk($sformatf("v%0d instr_pc", i), instr_pc, vecs[i].e_ipc);
            chk($sformatf("v%0d instr_data", i), {32'd0, instr_data}, {32'd0, mem_word(vecs[i].e_ipc)});
         end
         next_cycle();
      end
      chk("accepted requests", 64'(req_count), 64'd9);

      // A: redirect on full queue with pop, then redirect coincident with response
      instr_ready = 1'b1; redirect = 1'b1; redirect_pc = 64'h3000;
      @(negedge clk);
      chk("A full redirect req_valid", {63'd0, imem_req_valid}, 64'd0);
      chk("A full head pc", instr_pc, 64'h4);
      next_cycle();
      redirect = 1'b0;
      @(negedge clk);
      chk("A flushed instr_valid", {63'd0, instr_valid}, 64'd0);
      chk("A target req_valid", {63'd0, imem_req_valid}, 64'd1);
      chk("A target req_addr", imem_req_addr, 64'h3000);
      next_cycle();
      redirect = 1'b1; redirect_pc = 64'h4000;
      @(negedge clk);
      chk("A resp redirect req_valid", {63'd0, imem_req_valid}, 64'd0);
      next_cycle();
      redirect = 1'b0;
      @(negedge clk);
      chk("A after resp redirect instr_valid", {63'd0, instr_valid}, 64'd0);
      chk("A after resp redirect req_addr", imem_req_addr, 64'h4000);
      chk("A after resp redirect req_valid", {63'd0, imem_req_valid}, 64'd1);
      next_cycle();
      @(negedge clk);
      chk("A wait instr_valid", {63'd0, instr_valid}, 64'd0);
      next_cycle();
      @(negedge clk);
      chk("A new instr_valid", {63'd0, instr_valid}, 64'd1);
      chk("A new instr_pc", instr_pc, 64'h4000);
      chk("A new instr_data", {32'd0, instr_data}, {32'd0, mem_word(64'h4000)});
      next_cycle();

      // B: redirect while a 3-cycle read is in flight
      prep(64'h7000, 3);
      @(negedge clk);
      chk("B req_addr", imem_req_addr, 64'h7000);
      chk("B req_valid", {63'd0, imem_req_valid}, 64'd1);
      next_cycle();
      redirect = 1'b1; redirect_pc = 64'h2002;
      @(negedge clk);
      chk("B wait req_valid", {63'd0, imem_req_valid}, 64'd0);
      next_cycle();
      redirect = 1'b0;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         chk($sformatf("B drop%0d req_valid", k), {63'd0, imem_req_valid}, 64'd0);
         chk($sformatf("B drop%0d instr_valid", k), {63'd0, instr_valid}, 64'd0);
         next_cycle();
      end
      @(negedge clk);
      chk("B target req_valid", {63'd0, imem_req_valid}, 64'd1);
      chk("B target req_addr", imem_req_addr, 64'h2000);
      chk("B no stale instr", {63'd0, instr_valid}, 64'd0);
      next_cycle();
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk($sformatf("B wait%0d instr_valid", k), {63'd0, instr_valid}, 64'd0);
         next_cycle();
      end
      @(negedge clk);
      chk("B first instr_valid", {63'd0, instr_valid}, 64'd1);
      chk("B first instr_pc", instr_pc, 64'h2000);
      chk("B first instr_data", {32'd0, instr_data}, {32'd0, mem_word(64'h2000)});
      next_cycle();

      // C: address wrap at the top of the address space
      prep(64'hFFFF_FFFF_FFFF_FFFC, 1);
      @(negedge clk);
      chk("C first req_addr", imem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
      next_cycle();
      @(negedge clk);
      next_cycle();
      @(negedge clk);
      chk("C second req_valid", {63'd0, imem_req_valid}, 64'd1);
      chk("C second req_addr", imem_req_addr, 64'h0);
      chk("C instr_pc", instr_pc, 64'hFFFF_FFFF_FFFF_FFFC);
      next_cycle();

      // D: asynchronous reset mid-WAIT with two queued entries
      prep(64'h5000, 1);
      instr_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         next_cycle();
      end
      lat = 3;
      @(negedge clk);
      chk("D queued head pc", instr_pc, 64'h5000);
      chk("D third req_addr", imem_req_addr, 64'h5008);
      next_cycle();
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      pend = 1'b0;
      imem_resp_valid = 1'b0;
      chk("D reset instr_valid", {63'd0, instr_valid}, 64'd0);
      chk("D reset req_addr", imem_req_addr, 64'h1000);
      chk("D reset instr_pc", instr_pc, 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("D release req_valid", {63'd0, imem_req_valid}, 64'd1);
      chk("D release req_addr", imem_req_addr, 64'h1000);
      chk("D release instr_valid", {63'd0, instr_valid}, 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/instr_fetch_queue.md
# instr_fetch_queue

Instruction fetch unit that consumes the program-counter stream: it holds the current fetch address, issues word reads to instruction memory through a valid/ready request channel with variable-latency responses, and buffers returned instructions (with their PCs) in a small FIFO for decode. A taken-branch redirect from the PC/branch logic flushes the queue, discards any in-flight response and restarts fetching at the redirect target. The block sits between the PC/branch-target logic and the decode stage of the single-cycle core's fetch path.

## Interface
- RESET_PC, 64'd0: first fetch address after reset.
- DEPTH, 4: FIFO entries; power of two, ≥2.

- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- redirect  in  1  taken branch (ANDBranch); load redirect_pc, flush.
- redirect_pc  in  64  branch target (PC + shifted immediate); bits [1:0] ignored, forced 0.
- imem_req_valid  out  1  fetch request present.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  64  fetch address, word aligned.
- imem_resp_valid  in  1  read data returned (exactly one per accepted request, ≥1 cycle after acceptance).
- imem_resp_data  in  32  instruction word.
- instr_valid  out  1  FIFO non-empty.
- instr_ready  in  1  decode consumes head.
- instr_data  out  32  head instruction.
- instr_pc  out  64  address of head instruction.

## Operation
- Registers: fetch_addr[63:0], state, FIFO (DEPTH × {pc, data}), count (0..DEPTH), read/write pointers.
- States: FETCH, WAIT, DROP.
  - FETCH: imem_req_valid = (count < DEPTH) && !redirect; imem_req_addr = fetch_addr. On acceptance (valid && ready): fetch_addr += 4 (mod 2^64, wraps), → WAIT.
  - WAIT: no request. On imem_resp_valid: push {pc = fetch_addr − 4, data}, → FETCH.
  - DROP: no request. On imem_resp_valid: discard data, → FETCH.
- Slot reservation: request only issued with count < DEPTH; count cannot grow while waiting, so push never overflows.
- Pop: instr_valid && instr_ready removes head; simultaneous push and pop leave count unchanged.
- Redirect (priority over everything else in that cycle):
  - FIFO cleared (count=0, pointers reset); pop ignored; fetch_addr ← {redirect_pc[63:2], 2'b00}.
  - FETCH → FETCH (imem_req_valid forced low that cycle; memory must tolerate withdrawal).
  - WAIT without resp → DROP; WAIT with resp same cycle → response discarded, → FETCH.
  - DROP without resp → stays DROP; DROP with resp → FETCH.
- Reset (asynchronous, any time incl. mid-request): state=FETCH, fetch_addr=RESET_PC, count=0, pointers=0. In-flight responses arriving after reset are the memory's responsibility to cancel (memory shares rst_n).

## Timing
- Reset values: imem_req_valid=1 once rst_n high (count=0, FETCH), imem_req_addr=RESET_PC, instr_valid=0, instr_data=0, instr_pc=0 (FIFO storage reset to 0).
- imem_req_valid/addr combinational from registered state; instr_* direct from FIFO registers.
- Response in cycle N → instr_valid in cycle N+1.
- Single-cycle memory (ready=1, resp one cycle after accept): request every 2 cycles; first instr_valid in cycle 2 after reset release.
- After redirect in cycle R: instr_valid=0 in R+1; new request at redirect target in R+1 if not DROP, else cycle after stale response.
- Full FIFO (count=DEPTH) in FETCH: imem_req_valid=0 until a pop; request asserted the cycle after count drops.

## Test plan
- Reset/stream: RESET_PC=0x1000, ready=1, 1-cycle memory returning addr-derived words, instr_ready=1 -> instr_pc sequence 0x1000,0x1004,0x1008, first instr_valid cycle 2, one instr per 2 cycles.
- Backpressure: instr_ready=0, DEPTH=4 -> exactly 4 requests (0x0..0xC), imem_req_valid low while full; one pop -> next request to 0x10 the following cycle.
- Redirect while WAIT (3-cycle latency): redirect_pc=0x2002 in cycle after accept -> stale word dropped, never on instr_*, next request addr 0x2000, first instr_pc=0x2000.
- Redirect coincident with resp_valid and with full FIFO + pop -> FIFO empty next cycle, response discarded, request to target next cycle.
- Wrap: RESET_PC=0xFFFF_FFFF_FFFF_FFFC -> second request addr 0x0.
- Async reset mid-WAIT with FIFO holding 2 entries -> instr_valid=0 immediately, imem_req_addr=RESET_PC, state FETCH.
